// File: rtl/ctrl_pipe.sv
// Control-signal pipeline ID/EX -> EX/MEM -> MEM/WB with load-use stall and flush handling.
// Define CTRL_PIPE_HAZARD_EN to enable stall detection and the saturating stall counter.
module ctrl_pipe #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       id_AluControl,
    input  logic             id_regWrite,
    input  logic             id_AluSrc,
    input  logic             id_Branch,
    input  logic             id_memtoReg,
    input  logic             id_memRead,
    input  logic             id_memWrite,
    input  logic             id_MOVZ,
    input  logic [4:0]       id_rn,
    input  logic [4:0]       id_rm,
    input  logic [4:0]       id_rd,
    input  logic             flush,
    output logic [3:0]       ex_AluControl,
    output logic             ex_AluSrc,
    output logic             ex_MOVZ,
    output logic             mem_Branch,
    output logic             mem_memRead,
    output logic             mem_memWrite,
    output logic             wb_regWrite,
    output logic             wb_memtoReg,
    output logic [4:0]       ex_rd,
    output logic [4:0]       mem_rd,
    output logic [4:0]       wb_rd,
    output logic             stall,
    output logic [CNT_W-1:0] stall_count
);

    typedef struct packed {
        logic [3:0] alu_ctl;
        logic       reg_write;
        logic       alu_src;
        logic       branch;
        logic       memto_reg;
        logic       mem_read;
        logic       mem_write;
        logic       movz;
    } ex_ctl_t;

    typedef struct packed {
        logic branch;
        logic mem_read;
        logic mem_write;
        logic reg_write;
        logic memto_reg;
    } mem_ctl_t;

    typedef struct packed {
        logic reg_write;
        logic memto_reg;
    } wb_ctl_t;

    ex_ctl_t  ex_ctl_q, ex_ctl_d;
    mem_ctl_t mem_ctl_q, mem_ctl_d;
    wb_ctl_t  wb_ctl_q, wb_ctl_d;
    logic [4:0] ex_rd_q, ex_rd_d;
    logic [4:0] mem_rd_q, mem_rd_d;
    logic [4:0] wb_rd_q, wb_rd_d;

    always_comb begin
        ex_ctl_d  = '{alu_ctl: id_AluControl, reg_write: id_regWrite, alu_src: id_AluSrc,
                      branch: id_Branch, memto_reg: id_memtoReg, mem_read: id_memRead,
                      mem_write: id_memWrite, movz: id_MOVZ};
        ex_rd_d   = id_rd;
        mem_ctl_d = '{branch: ex_ctl_q.branch, mem_read: ex_ctl_q.mem_read,
                      mem_write: ex_ctl_q.mem_write, reg_write: ex_ctl_q.reg_write,
                      memto_reg: ex_ctl_q.memto_reg};
        mem_rd_d  = ex_rd_q;
        wb_ctl_d  = '{reg_write: mem_ctl_q.reg_write, memto_reg: mem_ctl_q.memto_reg};
        wb_rd_d   = mem_rd_q;
        // Flush kills the two younger stages but keeps their register addresses.
        if (flush) begin
            ex_ctl_d  = '0;
            mem_ctl_d = '0;
        end else if (stall) begin
            ex_ctl_d = '0;
            ex_rd_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_ctl_q  <= '0;
            mem_ctl_q <= '0;
            wb_ctl_q  <= '0;
            ex_rd_q   <= '0;
            mem_rd_q  <= '0;
            wb_rd_q   <= '0;
        end else begin
            ex_ctl_q  <= ex_ctl_d;
            mem_ctl_q <= mem_ctl_d;
            wb_ctl_q  <= wb_ctl_d;
            ex_rd_q   <= ex_rd_d;
            mem_rd_q  <= mem_rd_d;
            wb_rd_q   <= wb_rd_d;
        end
    end

`ifdef CTRL_PIPE_HAZARD_EN
    logic [CNT_W-1:0] stall_count_q, stall_count_d;

    // XZR is never a real producer, so it cannot create a dependency.
    assign stall = ex_ctl_q.mem_read && (ex_rd_q != 5'd31) &&
                   ((ex_rd_q == id_rn) || (ex_rd_q == id_rm)) && !flush;

    always_comb begin
        stall_count_d = stall_count_q;
        if (stall && (stall_count_q != {CNT_W{1'b1}}))
            stall_count_d = stall_count_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) stall_count_q <= '0;
        else       stall_count_q <= stall_count_d;
    end

    assign stall_count = stall_count_q;
`else
    logic unused_src;
    assign unused_src  = ^{id_rn, id_rm};
    assign stall       = 1'b0;
    assign stall_count = '0;
`endif

    assign ex_AluControl = ex_ctl_q.alu_ctl;
    assign ex_AluSrc     = ex_ctl_q.alu_src;
    assign ex_MOVZ       = ex_ctl_q.movz;
    assign mem_Branch    = mem_ctl_q.branch;
    assign mem_memRead   = mem_ctl_q.mem_read;
    assign mem_memWrite  = mem_ctl_q.mem_write;
    assign wb_regWrite   = wb_ctl_q.reg_write;
    assign wb_memtoReg   = wb_ctl_q.memto_reg;
    assign ex_rd         = ex_rd_q;
    assign mem_rd        = mem_rd_q;
    assign wb_rd         = wb_rd_q;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Bench for ctrl_pipe: an instruction-history model checked every cycle, plus directed literal checks.
module tb_ctrl_pipe;

`ifdef CTRL_PIPE_HAZARD_EN
    localparam bit HZ = 1'b1;
`else
    localparam bit HZ = 1'b0;
`endif
    localparam int CW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic [3:0]    id_AluControl;
    logic          id_regWrite, id_AluSrc, id_Branch, id_memtoReg, id_memRead, id_memWrite, id_MOVZ;
    logic [4:0]    id_rn, id_rm, id_rd;
    logic          flush;
    logic [3:0]    ex_AluControl;
    logic          ex_AluSrc, ex_MOVZ, mem_Branch, mem_memRead, mem_memWrite, wb_regWrite, wb_memtoReg;
    logic [4:0]    ex_rd, mem_rd, wb_rd;
    logic          stall;
    logic [CW-1:0] stall_count;

    ctrl_pipe #(.CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .id_AluControl(id_AluControl), .id_regWrite(id_regWrite), .id_AluSrc(id_AluSrc),
        .id_Branch(id_Branch), .id_memtoReg(id_memtoReg), .id_memRead(id_memRead),
        .id_memWrite(id_memWrite), .id_MOVZ(id_MOVZ),
        .id_rn(id_rn), .id_rm(id_rm), .id_rd(id_rd), .flush(flush),
        .ex_AluControl(ex_AluControl), .ex_AluSrc(ex_AluSrc), .ex_MOVZ(ex_MOVZ),
        .mem_Branch(mem_Branch), .mem_memRead(mem_memRead), .mem_memWrite(mem_memWrite),
        .wb_regWrite(wb_regWrite), .wb_memtoReg(wb_memtoReg),
        .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
        .stall(stall), .stall_count(stall_count)
    );

    int nvec = 0;
    int nerr = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: every instruction that enters EX is recorded; EX shows the newest entry,
    // MEM the one before, WB the one before that. Flush/reset rewrite history entries.
    typedef struct packed {
        logic [3:0] alu;
        logic rw, src, br, m2r, mr, mw, movz;
        logic [4:0] rd;
    } slot_t;

    slot_t      hist [256];
    logic [7:0] n = 8'd2;
    int         mcnt = 0;
    bit         started = 1'b0;

    initial for (int i = 0; i < 256; i++) hist[i] = '0;

    function automatic bit model_stall();
        slot_t x;
        x = hist[n];
        return HZ && x.mr && (x.rd != 5'd31) && (x.rd == id_rn || x.rd == id_rm) && !flush;
    endfunction

    always @(posedge clk) begin : model
        slot_t e;
        bit    s;
        if (reset) begin
            n = n + 8'd1;
            hist[n] = '0;
            hist[n - 8'd1] = '0;
            hist[n - 8'd2] = '0;
            mcnt = 0;
            started = 1'b1;
        end else begin
            s = model_stall();
            e = '{alu: id_AluControl, rw: id_regWrite, src: id_AluSrc, br: id_Branch,
                  m2r: id_memtoReg, mr: id_memRead, mw: id_memWrite, movz: id_MOVZ, rd: id_rd};
            if (flush)  e = {11'b0, e.rd};
            else if (s) e = '0;
            n = n + 8'd1;
            hist[n] = e;
            if (flush) hist[n - 8'd1] = {11'b0, hist[n - 8'd1].rd};
            if (s && mcnt < (1 << CW) - 1) mcnt++;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            slot_t xe, xm, xw;
            xe = hist[n];
            xm = hist[n - 8'd1];
            xw = hist[n - 8'd2];
            check("ex_stage", {ex_AluControl, ex_AluSrc, ex_MOVZ, ex_rd}, {xe.alu, xe.src, xe.movz, xe.rd});
            check("mem_stage", {mem_Branch, mem_memRead, mem_memWrite, mem_rd}, {xm.br, xm.mr, xm.mw, xm.rd});
            check("wb_stage", {wb_regWrite, wb_memtoReg, wb_rd}, {xw.rw, xw.m2r, xw.rd});
            check("stall", stall, model_stall());
            check("stall_count", stall_count, mcnt);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_AluControl = '0; id_regWrite = 0; id_AluSrc = 0; id_Branch = 0; id_memtoReg = 0;
        id_memRead = 0; id_memWrite = 0; id_MOVZ = 0; id_rn = 0; id_rm = 0; id_rd = 0; flush = 0;
    endtask

    initial begin
        idle();
        reset = 1'b1;
        step(); step();
        check("rst_ctl", {ex_AluControl, ex_AluSrc, ex_MOVZ, mem_Branch, mem_memRead, mem_memWrite,
                          wb_regWrite, wb_memtoReg}, 0);
        check("rst_rd", {ex_rd, mem_rd, wb_rd}, 0);
        check("rst_cnt", stall_count, 0);
        reset = 1'b0;
        step();

        // Propagation of one ALU op to WB
        id_regWrite = 1; id_memtoReg = 1; id_AluControl = 4'b0010; id_rd = 5'd4;
        step();
        idle();
        check("prop_ex_alu", ex_AluControl, 4'b0010);
        check("prop_ex_rd", ex_rd, 5'd4);
        step(); step();
        check("prop_wb", {wb_regWrite, wb_memtoReg, wb_rd}, {2'b11, 5'd4});
        step();
        check("prop_wb_clr", {wb_regWrite, wb_memtoReg}, 0);

        // Load-use on rn
        id_memRead = 1; id_rd = 5'd5;
        step();
        idle(); id_rn = 5'd5; id_rd = 5'd6; id_AluSrc = 1;
        check("lu_stall", stall, HZ);
        step();
        check("lu_ex_bubble", ex_AluSrc, !HZ);
        check("lu_stall_drop", stall, 0);
        check("lu_cnt", stall_count, HZ ? 1 : 0);
        step();
        idle();
        check("lu_replay", ex_AluSrc, 1);

        // XZR exemption
        id_memRead = 1; id_rd = 5'd31;
        step();
        idle(); id_rm = 5'd31;
        check("xzr_stall", stall, 0);
        step();
        idle();
        check("xzr_cnt", stall_count, HZ ? 1 : 0);

        // Flush beats hazard
        id_memRead = 1; id_rd = 5'd7; id_regWrite = 1; id_memtoReg = 1;
        step();
        idle(); id_rn = 5'd7; flush = 1; id_AluSrc = 1; id_rd = 5'd9;
        check("fl_stall", stall, 0);
        step();
        idle();
        check("fl_ex", {ex_AluSrc, ex_rd}, {1'b0, 5'd9});
        check("fl_mem", {mem_memRead, mem_rd}, {1'b0, 5'd7});
        check("fl_cnt", stall_count, HZ ? 1 : 0);
        step();
        check("fl_wb", {wb_regWrite, wb_memtoReg}, 0);

        // Five load-use pairs saturate the 2-bit counter
        for (int k = 0; k < 5; k++) begin
            idle(); id_memRead = 1; id_rd = 5'd3;
            step();
            idle(); id_rm = 5'd3;
            step(); step();
        end
        idle();
        check("sat_cnt", stall_count, HZ ? 3 : 0);
        step(); step();
        check("sat_hold", stall_count, HZ ? 3 : 0);

        // Mixed directed table
        for (int i = 0; i < 12; i++) begin
            id_AluControl = i[3:0]; id_regWrite = i[0]; id_AluSrc = i[1]; id_Branch = i[2];
            id_memtoReg = ~i[0]; id_memRead = (i % 3 == 0); id_memWrite = i[3]; id_MOVZ = i[1] ^ i[0];
            id_rd = 5'(i * 3); id_rn = 5'(i * 3 - 3); id_rm = 5'(i + 1); flush = (i == 7);
            step();
        end
        idle();
        step(); step(); step();

        // Reset while a store is in flight
        id_memWrite = 1; id_rd = 5'd12;
        step();
        idle(); reset = 1'b1;
        step();
        reset = 1'b0;
        check("rmf_ctl", {ex_AluControl, ex_AluSrc, ex_MOVZ, mem_Branch, mem_memRead, mem_memWrite,
                          wb_regWrite, wb_memtoReg}, 0);
        check("rmf_rd", {ex_rd, mem_rd, wb_rd}, 0);
        check("rmf_cnt", stall_count, 0);
        for (int k = 0; k < 3; k++) begin
            step();
            check("rmf_mw", mem_memWrite, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/ctrl_pipe.md
CTRL_PIPE -- requirements
Module: ctrl_pipe

Interface
REQ-001 Parameter CNT_W, default 16: width of the stall-event counter.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 id_AluControl  input  4  ALU control from the decode-stage controller.
REQ-005 id_regWrite, id_AluSrc, id_Branch, id_memtoReg, id_memRead, id_memWrite, id_MOVZ  input  1 each  decode-stage control bits.
REQ-006 id_rn, id_rm  input  5 each  decode-stage source registers, taken after the reg2loc selection.
REQ-007 id_rd  input  5  decode-stage destination register.
REQ-008 flush  input  1  branch taken, resolved in MEM.
REQ-009 ex_AluControl  output  4; ex_AluSrc, ex_MOVZ  output  1 each  EX-stage controls.
REQ-010 mem_Branch, mem_memRead, mem_memWrite  output  1 each  MEM-stage controls.
REQ-011 wb_regWrite, wb_memtoReg  output  1 each  WB-stage controls.
REQ-012 ex_rd, mem_rd, wb_rd  output  5 each  staged destination registers.
REQ-013 stall  output  1  combinational; freezes the PC and the IF/ID register.
REQ-014 stall_count  output  CNT_W  number of bubbles inserted by load-use stalls.

Function
REQ-015 ID/EX stage: on each edge, capture all id_* control bits and id_rd. Outputs appear on ex_* one cycle later, mem_* two cycles later and wb_* three cycles later.
REQ-016 EX/MEM stage: on each edge, capture the MEM and WB groups and ex_rd from ID/EX.
REQ-017 MEM/WB stage: on each edge, capture the WB group and mem_rd from EX/MEM.
REQ-018 stall = ex_memRead AND ex_rd != 31 AND (ex_rd == id_rn OR ex_rd == id_rm) AND NOT flush.
REQ-019 Destination register 31 (XZR) never causes a stall.
REQ-020 stall=1: ID/EX loads all-zero control (bubble); ID/EX rd loads 0; EX/MEM and MEM/WB advance normally.
REQ-021 flush=1: ID/EX and EX/MEM control bits load zero at the next edge; MEM/WB advances normally.
REQ-022 Simultaneous flush and hazard: flush wins; stall=0; the bubble is not counted.
REQ-023 stall_count increments by 1 on each edge where stall=1.
REQ-024 stall_count saturates at 2^CNT_W-1; there is no wrap-around.
REQ-025 Register-address fields (rd) are not cleared by flush; only control bits are cleared.
REQ-026 A stall lasts exactly one cycle per load-use pair. The bubble clears ex_memRead, so stall drops on the following cycle.

Reset
REQ-027 reset=1 at an edge: all control outputs 0; ex_rd, mem_rd, wb_rd 0; stall_count 0.
REQ-028 reset has priority over flush and stall.
REQ-029 While reset is held, stall evaluates to 0 because ex_memRead is 0.
REQ-030 A reset asserted mid-stall or mid-flush discards all in-flight controls; none appear after reset releases.

Configuration
REQ-031 Macro CTRL_PIPE_HAZARD_EN defined: stall detection and stall_count operate per REQ-018..REQ-024.
REQ-032 Macro CTRL_PIPE_HAZARD_EN undefined: stall tied to 0 and stall_count tied to 0; flush and staging behaviour are unchanged.

Verification
REQ-033 Propagation: id_regWrite=1, id_memtoReg=1, id_AluControl=4'b0010 for one cycle -> ex_AluControl=0010 at +1, wb_regWrite=1 and wb_memtoReg=1 at +3, all 0 afterwards.
REQ-034 Load-use hazard:
  - stimulus: LDUR with id_memRead=1, id_rd=5, then next cycle id_rn=5;
  - response: stall=1 for exactly one cycle, ex_* all 0 the cycle after, stall_count=1.
REQ-035 XZR exemption: load with id_rd=31 followed by id_rm=31 -> stall stays 0 and stall_count stays 0.
REQ-036 Flush priority:
  - stimulus: hazard condition and flush=1 in the same cycle;
  - response: stall=0, ex_* and mem_* controls 0 next cycle, wb_* unchanged pipeline, stall_count unchanged.
REQ-037 Saturation: CNT_W=2, five back-to-back load-use pairs -> stall_count reads 3 and holds 3.
REQ-038 Reset mid-flight: reset=1 one cycle after issuing id_memWrite=1 -> mem_memWrite never asserts and all outputs are 0 after reset.
